exe_seq_ctrl: RTL and testbench
===============================

EXE_SEQ_CTRL -- requirements
Module: exe_seq_ctrl

Interface
REQ-001 Parameter PC_W, default 6, program-counter and instruction-address width.
REQ-002 Parameter IW, default 24, instruction word width; fixed layout per REQ-013.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rsn  in  1  reset, asynchronous, active-low.
REQ-005 i_start, i_start_pc  in  1, PC_W  start pulse and program entry address.
REQ-006 o_ireq, o_iaddr, i_iack, i_idata  out 1, out PC_W, in 1, in IW  instruction-fetch handshake.
REQ-007 o_oper, o_imm, o_reg0, o_reg1, o_data  out 3, 1, 4, 4, 6 (signed)  EXE operand/operation controls.
REQ-008 i_result, i_flag  in 6 (signed), 4  EXE result and flags.
REQ-009 o_wen, o_reg2, o_data2  out 1, 4, 6 (signed)  register-file write port.
REQ-010 o_busy, o_done, o_err  out 1 each  running, 1-cycle halt pulse, sticky reserved-opcode flag.

Function
REQ-011 FSM states IDLE, FETCH, EXEC, WB, DONE; IDLE after reset.
REQ-012 IDLE: i_start=1 loads PC<=i_start_pc, clears o_err, goes FETCH; i_start ignored in every other state.
REQ-013 Instruction: [23:22] class (00 ALU, 01 JMP, 10 HALT, 11 reserved), [21:19] oper, [18] imm, [17:14] dst (JMP: cond mask), [13:10] src0, [9:6] src1, [5:0] data (JMP: target).
REQ-014 FETCH: o_ireq=1, o_iaddr=PC held stable until i_iack=1; ack in same cycle as first request permitted; on ack IR<=i_idata, PC<=PC+1 modulo 2^PC_W, go EXEC.
REQ-015 EXEC, class ALU: o_oper/o_imm/o_reg0/o_reg1/o_data driven from IR for exactly one cycle; i_result and i_flag captured at that edge into RES and FLG; go WB.
REQ-016 WB: o_wen=1, o_reg2=dst, o_data2=RES for exactly one cycle; go FETCH.
REQ-017 EXEC, class JMP: taken if mask==0 or (mask & FLG)!=0; taken sets PC<=target (overriding increment); FLG unchanged; go FETCH, no WB.
REQ-018 EXEC, class HALT: go DONE; DONE asserts o_done one cycle, then IDLE.
REQ-019 EXEC, class reserved: treated as NOP, o_err<=1 (sticky until next accepted start), go FETCH.
REQ-020 Outside EXEC, EXE control outputs held at 0; outside WB, o_wen=0; outside FETCH, o_ireq=0.
REQ-021 o_busy=1 in FETCH, EXEC, WB; 0 in IDLE and DONE.
REQ-022 Latency: ALU instruction = fetch wait + 3 cycles (ack same cycle); JMP = fetch + 2; JMP reads FLG from most recent ALU instruction.
REQ-023 PC wrap: fetch from address 2^PC_W-1 followed by address 0, no error.

Reset
REQ-024 i_rsn=0 forces immediately: state IDLE, PC=0, IR=0, RES=0, FLG=0, all outputs 0.
REQ-025 Reset during FETCH drops o_ireq same instant; pending ack after release ignored (IDLE).
REQ-026 Reset during WB suppresses the write (o_wen=0 immediately).

Structure
REQ-027 Shared package holds class codes, instruction field positions/widths, FSM state encoding, data width 6 and register-address width 4.
REQ-028 Single module; optional sub-module exe_seq_decode (combinational IR field/branch-condition decode).

Verification
REQ-029 Reset release, i_start=1 pc=5, ack same cycle, IR=ALU oper=3 dst=2 src0=1 src1=4 -> o_iaddr=5, EXEC 1 cycle oper=3, WB o_wen=1 o_reg2=2 o_data2=i_result captured.
REQ-030 Fetch with i_iack delayed 4 cycles -> o_ireq/o_iaddr stable 5 cycles, single IR load, PC+1 once.
REQ-031 ALU gives i_flag=4'b0010, then JMP mask=0010 target=9 -> next o_iaddr=9; mask=0100 -> next o_iaddr=PC+1.
REQ-032 Program starting at 63 -> next fetch address 0; HALT -> o_done single pulse, o_busy=0, return IDLE; i_start during busy ignored.
REQ-033 Class 11 instruction -> no o_wen, o_err=1 stays set until next i_start accepted.
REQ-034 i_rsn low mid-WB and mid-FETCH -> o_wen and o_ireq drop asynchronously, state IDLE, all outputs 0.

Source files
------------

// File: rtl/exe_seq_ctrl_pkg.sv
// Shared definitions for the EXE sequencer: instruction layout, class codes, FSM encoding.
package exe_seq_ctrl_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned DATA_W  = 6;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned OPER_W  = 3;
  localparam int unsigned CLS_W   = 2;

  localparam int unsigned CLS_LSB  = 22;
  localparam int unsigned OPER_LSB = 19;
  localparam int unsigned IMM_POS  = 18;
  localparam int unsigned DST_LSB  = 14;
  localparam int unsigned SRC0_LSB = 10;
  localparam int unsigned SRC1_LSB = 6;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [CLS_W-1:0] {
    CLS_ALU  = 2'b00,
    CLS_JMP  = 2'b01,
    CLS_HALT = 2'b10,
    CLS_RSVD = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // dst doubles as the condition mask and data as the target for JMP
  typedef struct packed {
    cls_e              cls;
    logic [OPER_W-1:0] oper;
    logic              imm;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  src0;
    logic [REG_W-1:0]  src1;
    logic [DATA_W-1:0] data;
  } instr_t;

  typedef struct packed {
    logic [OPER_W-1:0] oper;
    logic              imm;
    logic [REG_W-1:0]  reg0;
    logic [REG_W-1:0]  reg1;
    logic [DATA_W-1:0] data;
  } exe_ctrl_t;

  function automatic instr_t instr_decode(input logic [INSTR_W-1:0] w);
    instr_t f;
    f.cls  = cls_e'(w[CLS_LSB +: CLS_W]);
    f.oper = w[OPER_LSB +: OPER_W];
    f.imm  = w[IMM_POS];
    f.dst  = w[DST_LSB +: REG_W];
    f.src0 = w[SRC0_LSB +: REG_W];
    f.src1 = w[SRC1_LSB +: REG_W];
    f.data = w[DATA_LSB +: DATA_W];
    return f;
  endfunction

  function automatic logic jmp_taken(input logic [REG_W-1:0] mask, input logic [REG_W-1:0] flg);
    return (mask == '0) || ((mask & flg) != '0);
  endfunction

endpackage

// File: rtl/exe_seq_decode.sv
// Combinational decode of the held instruction and its branch condition.
module exe_seq_decode
  import exe_seq_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  input  logic [REG_W-1:0]   flg,
  output instr_t             fields,
  output logic               taken
);

  always_comb begin
    fields = instr_decode(ir);
    taken  = jmp_taken(fields.dst, flg);
  end

endmodule

// File: rtl/exe_seq_ctrl.sv
// Instruction sequencer: fetches, drives EXE controls, writes back results, handles jumps/halt.
module exe_seq_ctrl
  import exe_seq_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 6,
  parameter int unsigned IW   = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rsn,
  input  logic                     i_start,
  input  logic [PC_W-1:0]          i_start_pc,
  output logic                     o_ireq,
  output logic [PC_W-1:0]          o_iaddr,
  input  logic                     i_iack,
  input  logic [IW-1:0]            i_idata,
  output logic [OPER_W-1:0]        o_oper,
  output logic                     o_imm,
  output logic [REG_W-1:0]         o_reg0,
  output logic [REG_W-1:0]         o_reg1,
  output logic signed [DATA_W-1:0] o_data,
  input  logic signed [DATA_W-1:0] i_result,
  input  logic [REG_W-1:0]         i_flag,
  output logic                     o_wen,
  output logic [REG_W-1:0]         o_reg2,
  output logic signed [DATA_W-1:0] o_data2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  state_e                   state, state_d;
  logic [PC_W-1:0]          pc, pc_d;
  logic [INSTR_W-1:0]       ir, ir_d;
  logic signed [DATA_W-1:0] res, res_d;
  logic [REG_W-1:0]         flg, flg_d;
  logic                     err_d;
  instr_t                   ir_f, nxt_f;
  logic                     taken;

  logic                     ireq_d, wen_d, busy_d, done_d;
  logic [PC_W-1:0]          iaddr_d;
  exe_ctrl_t                exe_d;
  logic [REG_W-1:0]         reg2_d;
  logic signed [DATA_W-1:0] data2_d;

  exe_seq_decode u_dec (
    .ir     (ir),
    .flg    (flg),
    .fields (ir_f),
    .taken  (taken)
  );

  // Next-state and next-output logic; outputs are registered from the upcoming state
  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    res_d   = res;
    flg_d   = flg;
    err_d   = o_err;
    nxt_f   = ir_f;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          pc_d    = i_start_pc;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_iack) begin
          ir_d    = INSTR_W'(i_idata);
          nxt_f   = instr_decode(INSTR_W'(i_idata));
          pc_d    = pc + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (ir_f.cls)
          CLS_ALU: begin
            res_d   = i_result;
            flg_d   = i_flag;
            state_d = ST_WB;
          end
          CLS_JMP: begin
            if (taken) pc_d = PC_W'(ir_f.data);
            state_d = ST_FETCH;
          end
          CLS_HALT: state_d = ST_DONE;
          default: begin
            err_d   = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_WB:   state_d = ST_FETCH;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ireq_d  = (state_d == ST_FETCH);
    iaddr_d = ireq_d ? pc_d : '0;
    exe_d   = '0;
    if (state_d == ST_EXEC && nxt_f.cls == CLS_ALU) begin
      exe_d.oper = nxt_f.oper;
      exe_d.imm  = nxt_f.imm;
      exe_d.reg0 = nxt_f.src0;
      exe_d.reg1 = nxt_f.src1;
      exe_d.data = nxt_f.data;
    end
    wen_d   = (state_d == ST_WB);
    reg2_d  = wen_d ? nxt_f.dst : '0;
    data2_d = wen_d ? res_d : '0;
    busy_d  = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_WB);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      res     <= '0;
      flg     <= '0;
      o_err   <= 1'b0;
      o_ireq  <= 1'b0;
      o_iaddr <= '0;
      o_oper  <= '0;
      o_imm   <= 1'b0;
      o_reg0  <= '0;
      o_reg1  <= '0;
      o_data  <= '0;
      o_wen   <= 1'b0;
      o_reg2  <= '0;
      o_data2 <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      ir      <= ir_d;
      res     <= res_d;
      flg     <= flg_d;
      o_err   <= err_d;
      o_ireq  <= ireq_d;
      o_iaddr <= iaddr_d;
      o_oper  <= exe_d.oper;
      o_imm   <= exe_d.imm;
      o_reg0  <= exe_d.reg0;
      o_reg1  <= exe_d.reg1;
      o_data  <= exe_d.data;
      o_wen   <= wen_d;
      o_reg2  <= reg2_d;
      o_data2 <= data2_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Self-checking bench for exe_seq_ctrl: the bench acts as instruction memory and EXE unit
// and checks every cycle against an instruction-level model of the program.
module tb_exe_seq_ctrl;

  logic              clk = 1'b0;
  logic              i_rsn, i_start, i_iack;
  logic [5:0]        i_start_pc;
  logic [23:0]       i_idata;
  logic signed [5:0] i_result;
  logic [3:0]        i_flag;
  logic              o_ireq, o_imm, o_wen, o_busy, o_done, o_err;
  logic [5:0]        o_iaddr;
  logic [2:0]        o_oper;
  logic [3:0]        o_reg0, o_reg1, o_reg2;
  logic signed [5:0] o_data, o_data2;

  int n_vec = 0;
  int n_err = 0;

  // program memory and instruction-level model state
  logic [23:0] mem [64];
  logic [5:0]  m_pc;
  logic [3:0]  m_flg;
  logic        m_err;
  int          fix_dly, max_dly, limit;
  logic        flg_force_en;
  logic [3:0]  flg_force;

  localparam logic [23:0] HALT_W = 24'h800000;

  exe_seq_ctrl #(.PC_W(6), .IW(24)) dut (
    .i_clk(clk), .i_rsn(i_rsn), .i_start(i_start), .i_start_pc(i_start_pc),
    .o_ireq(o_ireq), .o_iaddr(o_iaddr), .i_iack(i_iack), .i_idata(i_idata),
    .o_oper(o_oper), .o_imm(o_imm), .o_reg0(o_reg0), .o_reg1(o_reg1), .o_data(o_data),
    .i_result(i_result), .i_flag(i_flag),
    .o_wen(o_wen), .o_reg2(o_reg2), .o_data2(o_data2),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input logic [1:0] c, input logic [2:0] op, input logic im,
                                     input logic [3:0] d, input logic [3:0] s0, input logic [3:0] s1,
                                     input logic [5:0] dat);
    return {c, op, im, d, s0, s1, dat};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ireq"},  32'(o_ireq), 32'd0);
    chk({tag, ".iaddr"}, 32'(o_iaddr), 32'd0);
    chk({tag, ".oper"},  32'(o_oper), 32'd0);
    chk({tag, ".imm"},   32'(o_imm), 32'd0);
    chk({tag, ".reg0"},  32'(o_reg0), 32'd0);
    chk({tag, ".reg1"},  32'(o_reg1), 32'd0);
    chk({tag, ".data"},  {26'd0, o_data}, 32'd0);
    chk({tag, ".wen"},   32'(o_wen), 32'd0);
    chk({tag, ".reg2"},  32'(o_reg2), 32'd0);
    chk({tag, ".data2"}, {26'd0, o_data2}, 32'd0);
    chk({tag, ".busy"},  32'(o_busy), 32'd0);
    chk({tag, ".done"},  32'(o_done), 32'd0);
    chk({tag, ".err"},   32'(o_err), 32'd0);
  endtask

  // asynchronous reset between clock edges, outputs must clear without a clock
  task automatic do_abort();
    #2 i_rsn = 1'b0;
    #1 chk_zero("async_rst");
    i_start = 1'b0;
    i_iack  = 1'b1;
    i_idata = 24'($urandom);
    m_flg   = '0;
    m_err   = 1'b0;
  endtask

  // release with an acknowledge still pending: design must stay idle
  task automatic release_rst();
    @(negedge clk);
    i_rsn = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    @(negedge clk);
    chk_zero("post_rst2");
    i_iack = 1'b0;
  endtask

  // abort_mode: 0 run to HALT, 1 reset in first write-back, 2 reset in second fetch-wait cycle
  task automatic run_prog(input logic [5:0] pc0, input int abort_mode);
    int                n_exec;
    int                d;
    bit                fin;
    logic [23:0]       w;
    logic              alu;
    logic signed [5:0] res;
    logic [3:0]        fl, mask;
    @(negedge clk);
    i_start    = 1'b1;
    i_start_pc = pc0;
    m_pc       = pc0;
    m_err      = 1'b0;
    n_exec     = 0;
    fin        = 1'b0;
    while (!fin) begin
      w = (n_exec >= limit) ? HALT_W : mem[m_pc];
      d = (fix_dly >= 0) ? fix_dly : int'($urandom_range(max_dly, 0));
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        chk("fetch.ireq",  32'(o_ireq), 32'd1);
        chk("fetch.iaddr", 32'(o_iaddr), 32'(m_pc));
        chk("fetch.busy",  32'(o_busy), 32'd1);
        chk("fetch.wen",   32'(o_wen), 32'd0);
        chk("fetch.err",   32'(o_err), 32'(m_err));
        if (abort_mode == 2 && k == 1) begin
          do_abort();
          return;
        end
        i_start    = 1'($urandom_range(1, 0));
        i_start_pc = 6'($urandom);
        i_iack     = (k == d);
        i_idata    = (k == d) ? w : 24'($urandom);
      end
      m_pc   = m_pc + 6'd1;
      n_exec++;

      @(negedge clk);
      i_iack = 1'b0;
      alu    = (w[23:22] == 2'b00);
      chk("exec.oper", 32'(o_oper), alu ? 32'(w[21:19]) : 32'd0);
      chk("exec.imm",  32'(o_imm),  alu ? 32'(w[18]) : 32'd0);
      chk("exec.reg0", 32'(o_reg0), alu ? 32'(w[13:10]) : 32'd0);
      chk("exec.reg1", 32'(o_reg1), alu ? 32'(w[9:6]) : 32'd0);
      chk("exec.data", {26'd0, o_data}, alu ? 32'(w[5:0]) : 32'd0);
      chk("exec.ireq", 32'(o_ireq), 32'd0);
      chk("exec.wen",  32'(o_wen), 32'd0);
      chk("exec.busy", 32'(o_busy), 32'd1);
      chk("exec.err",  32'(o_err), 32'(m_err));
      res      = 6'($urandom);
      fl       = flg_force_en ? flg_force : 4'($urandom);
      i_result = res;
      i_flag   = fl;

      case (w[23:22])
        2'b00: begin
          m_flg = fl;
          @(negedge clk);
          chk("wb.wen",   32'(o_wen), 32'd1);
          chk("wb.reg2",  32'(o_reg2), 32'(w[17:14]));
          chk("wb.data2", {26'd0, o_data2}, {26'd0, res});
          chk("wb.oper",  32'(o_oper), 32'd0);
          chk("wb.ireq",  32'(o_ireq), 32'd0);
          chk("wb.busy",  32'(o_busy), 32'd1);
          if (abort_mode == 1) begin
            do_abort();
            return;
          end
        end
        2'b01: begin
          mask = w[17:14];
          if (mask == 4'd0 || (mask & m_flg) != 4'd0) m_pc = w[5:0];
        end
        2'b10: begin
          @(negedge clk);
          chk("done.done", 32'(o_done), 32'd1);
          chk("done.busy", 32'(o_busy), 32'd0);
          chk("done.ireq", 32'(o_ireq), 32'd0);
          chk("done.err",  32'(o_err), 32'(m_err));
          i_start = 1'b0;
          @(negedge clk);
          chk("idle.done", 32'(o_done), 32'd0);
          chk("idle.busy", 32'(o_busy), 32'd0);
          chk("idle.ireq", 32'(o_ireq), 32'd0);
          chk("idle.wen",  32'(o_wen), 32'd0);
          chk("idle.err",  32'(o_err), 32'(m_err));
          fin = 1'b1;
        end
        default: m_err = 1'b1;
      endcase
    end
  endtask

  initial begin
    i_rsn        = 1'b0;
    i_start      = 1'b0;
    i_start_pc   = '0;
    i_iack       = 1'b0;
    i_idata      = '0;
    i_result     = '0;
    i_flag       = '0;
    fix_dly      = -1;
    max_dly      = 3;
    limit        = 100;
    flg_force_en = 1'b0;
    flg_force    = '0;
    m_flg        = '0;
    m_err        = 1'b0;
    m_pc         = '0;
    for (int i = 0; i < 64; i++) mem[i] = HALT_W;

    #3 chk_zero("reset");
    @(negedge clk);
    i_rsn = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_reset");

    // single ALU instruction at 5, immediate acknowledge
    mem[5] = mk(2'b00, 3'd3, 1'b0, 4'd2, 4'd1, 4'd4, 6'h15);
    mem[6] = HALT_W;
    fix_dly = 0;
    run_prog(6'd5, 0);

    // acknowledge held off for four cycles
    mem[12] = mk(2'b00, 3'd6, 1'b1, 4'd9, 4'd3, 4'd7, 6'h2a);
    mem[13] = HALT_W;
    fix_dly = 4;
    run_prog(6'd12, 0);

    // taken jump on flag bit 1, then not-taken jump on bit 2
    fix_dly      = 0;
    flg_force_en = 1'b1;
    flg_force    = 4'b0010;
    mem[20] = mk(2'b00, 3'd1, 1'b0, 4'd5, 4'd0, 4'd1, 6'h01);
    mem[21] = mk(2'b01, 3'd0, 1'b0, 4'b0010, 4'd0, 4'd0, 6'd9);
    mem[9]  = mk(2'b00, 3'd2, 1'b1, 4'd6, 4'd2, 4'd3, 6'h3f);
    mem[10] = mk(2'b01, 3'd0, 1'b0, 4'b0100, 4'd0, 4'd0, 6'd30);
    mem[11] = HALT_W;
    run_prog(6'd20, 0);
    flg_force_en = 1'b0;

    // program counter wraps from 63 to 0
    fix_dly = -1;
    mem[63] = mk(2'b00, 3'd7, 1'b0, 4'd15, 4'd14, 4'd13, 6'h20);
    mem[0]  = HALT_W;
    run_prog(6'd63, 0);

    // reserved class sets a sticky error, cleared by the next accepted start
    mem[40] = mk(2'b11, 3'd5, 1'b1, 4'd3, 4'd3, 4'd3, 6'h11);
    mem[41] = HALT_W;
    run_prog(6'd40, 0);
    run_prog(6'd41, 0);

    // random programs with random acknowledge delays and stray start pulses
    limit = 12;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) begin
        int sel;
        sel = int'($urandom_range(9, 0));
        mem[i] = {(sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b11 : 2'b10, 22'($urandom)};
      end
      run_prog(6'($urandom), 0);
    end
    limit = 100;

    // reset asserted mid write-back, then mid fetch-wait
    mem[50] = mk(2'b00, 3'd4, 1'b0, 4'd8, 4'd1, 4'd2, 6'h07);
    mem[51] = HALT_W;
    fix_dly = 0;
    run_prog(6'd50, 1);
    release_rst();
    fix_dly = 3;
    run_prog(6'd50, 2);
    release_rst();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
